// File: rtl/div.sv
// Multi-cycle 32-bit divider: restoring algorithm, one quotient bit per clock.
// Result is {remainder, quotient}, with optional signed operands.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        neg1_q, neg1_d;
    logic        neg2_q, neg2_d;
    logic        ready_q, ready_d;
    logic [63:0] result_q, result_d;

    logic        accept;
    logic        abort;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [32:0] diff;
    logic [64:0] stepped;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign accept = start_i && !annul_i;
    assign abort  = !start_i || annul_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE: begin
                if (accept) begin
                    state_d = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_d = abort ? FREE : END;
            end
            ON: begin
                if (abort) begin
                    state_d = FREE;
                end else if (cnt_q == 6'd31) begin
                    state_d = END;
                end
            end
            END: begin
                if (abort) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // work_q[64:32] is the partial remainder with the next dividend bit already
    // shifted in; quotient bits accumulate from the LSB upward.
    always_comb begin
        dividend_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        divisor_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

        diff = work_q[64:32] - {1'b0, divisor_q};
        if (work_q[64:32] >= {1'b0, divisor_q}) begin
            stepped = {diff[31:0], work_q[31:0], 1'b1};
        end else begin
            stepped = {work_q[63:0], 1'b0};
        end

        quot_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~stepped[31:0] + 32'd1) : stepped[31:0];
        rem_fix  = (signed_q && neg1_q) ? (~stepped[64:33] + 32'd1) : stepped[64:33];

        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;

        case (state_q)
            FREE: begin
                if (accept) begin
                    cnt_d     = 6'd0;
                    work_d    = {32'd0, dividend_abs, 1'b0};
                    divisor_d = divisor_abs;
                    signed_d  = signed_div_i;
                    neg1_d    = opdata1_i[31];
                    neg2_d    = opdata2_i[31];
                end
            end
            BYZERO: begin
                work_d = '0;
            end
            ON: begin
                if (!abort) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        work_d = {rem_fix, 1'b0, quot_fix};
                    end else begin
                        work_d = stepped;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready_d  = 1'b0;
        result_d = '0;
        if (state_q == END && !abort) begin
            ready_d  = 1'b1;
            result_d = {work_q[64:33], work_q[31:0]};
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expected results are queued at issue and compared
// when ready_o rises, together with latency and the ready/result handshake.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] expQ[$];
    int          latQ[$];

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] modelDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        if (push) begin
            expQ.push_back(modelDiv(sgn, a, b));
            latQ.push_back((b == 32'd0) ? 2 : 33);
        end
    endtask

    // k counts edges from E0, so the edge index where ready is first seen is k-1.
    task automatic waitResult(input string tag);
        int          k;
        bit          seen;
        logic [63:0] exp;
        int          lat;
        k    = 0;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
            if (ready_o) seen = 1'b1;
        end
        exp = expQ.pop_front();
        lat = latQ.pop_front();
        checkOutput({tag, "_latency"}, 64'(k - 1), 64'(lat));
        checkOutput({tag, "_result"}, result_o, exp);
        @(posedge clk);
        #1;
        checkOutput({tag, "_hold"}, {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_readyDrop"}, {63'd0, ready_o}, 64'd0);
        checkOutput({tag, "_resultDrop"}, result_o, 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          anyReady;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 32'd100, 32'd7, 1'b1);
        waitResult("u100div7");
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1);
        waitResult("sNeg7div2");
        applyStimulus(1'b0, 32'hFFFFFFF9, 32'd2, 1'b1);
        waitResult("uNeg7div2");
        applyStimulus(1'b0, 32'h12345678, 32'd0, 1'b1);
        waitResult("divByZero");
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        waitResult("sOverflow");
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1);
        waitResult("uMaxDiv1");
        applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1);
        waitResult("s7divNeg2");

        // annul lands on E10; start stays high so 9/3 is accepted right after.
        anyReady = 1'b0;
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ready_o) anyReady = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        if (ready_o) anyReady = 1'b1;
        checkOutput("abort_noReady", {63'd0, anyReady}, 64'd0);
        checkOutput("abort_result", result_o, 64'd0);
        applyStimulus(1'b0, 32'd9, 32'd3, 1'b1);
        waitResult("afterAbort9div3");

        // Reset lands on E20 of an operation.
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReset_ready", {63'd0, ready_o}, 64'd0);
        checkOutput("midReset_result", result_o, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b1);
        waitResult("afterReset100div7");

        for (int i = 0; i < 6; i++) begin
            a   = $urandom;
            b   = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            sgn = 1'($urandom_range(0, 1));
            applyStimulus(sgn, a, b, 1'b1);
            waitResult($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit operands and a 64-bit result.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 signed_div_i  input  1  1 = signed division, 0 = unsigned; sampled at start acceptance.
REQ-005 opdata1_i  input  32  dividend; sampled at start acceptance.
REQ-006 opdata2_i  input  32  divisor; sampled at start acceptance.
REQ-007 start_i  input  1  request from the execute stage, held high until ready_o is seen.
REQ-008 annul_i  input  1  cancel the operation in flight, for example on a pipeline flush.
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}; written to HI/LO by the execute stage.
REQ-010 ready_o  output  1  result_o is valid.

Function
REQ-011 The block SHALL implement four states: FREE, BYZERO, ON and END.
REQ-012 FREE: start_i=1 and annul_i=0 with opdata2_i==0 SHALL go to BYZERO; start_i=1 and annul_i=0 with opdata2_i!=0 SHALL go to ON, latching the operands and clearing the iteration counter; otherwise the block SHALL stay in FREE with ready_o=0 and result_o=0.
REQ-013 Operand conditioning in FREE: when signed_div_i=1, each negative operand SHALL be replaced by its two's-complement magnitude; signed_div_i and both original sign bits SHALL be latched.
REQ-014 BYZERO: the block SHALL go to END on the next edge with quotient=0 and remainder=0.
REQ-015 ON: each cycle SHALL perform one restoring step on a 65-bit working register:
- shift the partial remainder left, bringing in the next dividend bit (MSB first);
- if the partial remainder is >= divisor, subtract the divisor and shift in quotient bit 1, else shift in 0;
- increment the 6-bit counter.
REQ-016 ON: after the 32nd step the block SHALL go to END and apply sign correction when signed_div_i=1:
- negate the quotient if the original operand signs differ;
- negate the remainder if the original dividend was negative.
REQ-017 END: ready_o SHALL be 1 and result_o SHALL hold the final value, both as registered outputs.
REQ-018 END: the block SHALL stay in END while start_i=1; when start_i=0 it SHALL go to FREE with ready_o=0 and result_o=0.
REQ-019 Latency (edge E0 is the edge that accepts start): ready_o SHALL be high after edge E33 for nonzero divisors and after edge E2 for a zero divisor.
REQ-020 Abort: start_i=0 or annul_i=1 in ON or BYZERO SHALL return the block to FREE on the next edge with ready_o=0 and result_o=0, and no result SHALL be produced.
REQ-021 Abort priority: annul_i=1 in END SHALL also return the block to FREE.
REQ-022 Operand changes after acceptance SHALL have no effect on the result.
REQ-023 Signed overflow: 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no exception).
REQ-024 Unsigned arithmetic SHALL be modulo 2^32 with no overflow flag.
REQ-025 A new start SHALL be accepted only in FREE; back-to-back operations therefore require start_i to drop for at least one cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL force state FREE, counter=0, working register=0, ready_o=0 and result_o=0, overriding all inputs.
REQ-027 rst mid-operation (ON, BYZERO or END) SHALL discard the operation; after rst is released, the first start SHALL behave identically to a post-power-up start.

Verification
REQ-028 Unsigned: 100 / 7, start held high -> ready_o after E33, result_o={0x00000002, 0x0000000E}.
REQ-029 Signed: -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; same operands unsigned -> quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-030 Zero divisor: 0x12345678 / 0 -> ready_o after E2, result_o=0; ready_o stays 1 until start_i drops, then returns to 0 on the next edge.
REQ-031 Overflow and extremes:
- signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000};
- unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
REQ-032 Abort: annul_i pulsed at E10 of 100/7 -> FREE, ready_o never asserted; an immediate new start of 9/3 -> {0, 3} after E33.
REQ-033 Reset: rst asserted at E20 of 100/7 -> all outputs 0 on the next edge; a fresh 100/7 then completes correctly.
